// File: rtl/alu_7seg_scan_if.sv
// alu_7seg_scan_if
//   Bundles the operand/strobe inputs and the display outputs of alu_7seg_scan.
//   master : operand source (drives a, b, opcode, e, load; observes seg, an, valid)
//   slave  : the ALU/display block itself
//   a, b    [WIDTH-1:0]  operands
//   opcode  [1:0]        00 ADD, 01 SUB, 10 AND, 11 XOR
//   e                    enable for load and display
//   load                 capture strobe
//   seg     [7:0]        {dp,g,f,e,d,c,b,a}, active-high
//   an      [DIGITS-1:0] one-hot digit enable, active-high
//   valid                result register holds a computed value
interface alu_7seg_scan_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [1:0]        opcode;
    logic              e;
    logic              load;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;
    logic              valid;

    modport master (
        output a, b, opcode, e, load,
        input  seg, an, valid
    );

    modport slave (
        input  a, b, opcode, e, load,
        output seg, an, valid
    );
endinterface

// File: rtl/alu_7seg_scan.sv
// alu_7seg_scan
//   Registered ALU feeding a time-multiplexed hexadecimal 7-segment display.
//   Operands are captured on load (when e=1); the result and its carry/borrow
//   flag are held in registers. A prescaled scan counter walks the digit
//   positions and the shared segment bus shows the matching result nibble.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_7seg_scan_if.slave (a, b, opcode, e, load in; seg, an, valid out)
module alu_7seg_scan #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 2,
    parameter int LZB      = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_7seg_scan_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NW = 4 * DIGITS;
    localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_TC = IW'(DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [WIDTH-1:0] r_q, r_d;
    logic             flag_q, flag_d;
    logic             valid_q, valid_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             en_q, en_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    // One extra bit on each side: the MSB is the carry (ADD) or borrow (SUB).
    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};

    // Next-state: ALU capture plus free-running scan.
    always_comb begin
        r_d     = r_q;
        flag_d  = flag_q;
        valid_d = valid_q;
        if (bus.e && bus.load) begin
            valid_d = 1'b1;
            case (bus.opcode)
                2'b00: begin
                    r_d    = sum_w[WIDTH-1:0];
                    flag_d = sum_w[WIDTH];
                end
                2'b01: begin
                    r_d    = diff_w[WIDTH-1:0];
                    flag_d = diff_w[WIDTH];
                end
                2'b10: begin
                    r_d    = bus.a & bus.b;
                    flag_d = 1'b0;
                end
                default: begin
                    r_d    = bus.a ^ bus.b;
                    flag_d = 1'b0;
                end
            endcase
        end

        // The scan never looks at load, so captures cannot jitter the display phase.
        presc_d = (presc_q == PRE_TC) ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_TC) begin
            idx_d = (idx_q == IDX_TC) ? '0 : idx_q + IW'(1);
        end

        // Registering e keeps the display free of any combinational input path.
        en_d = bus.e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            presc_q <= '0;
            en_q    <= 1'b0;
        end else begin
            r_q     <= r_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            en_q    <= en_d;
        end
    end

    logic [NW-1:0] r_pad;
    logic [3:0]    nib;
    logic          blank;
    logic          upper_zero;

    // Display decode from registers only. Walking from the top digit down,
    // upper_zero tracks whether this nibble and all above it are zero.
    always_comb begin
        r_pad      = NW'(r_q);
        nib        = 4'h0;
        blank      = 1'b0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (r_pad[4*k +: 4] == 4'h0);
            if (IW'(k) == idx_q) begin
                nib   = r_pad[4*k +: 4];
                blank = upper_zero && (k != 0);
            end
        end

        bus.seg   = 8'h00;
        bus.an    = '0;
        bus.valid = valid_q;
        if (en_q && valid_q) begin
            bus.an = DIGITS'(1) << idx_q;
            if (!((LZB != 0) && blank)) begin
                bus.seg[6:0] = hex7(nib);
            end
            bus.seg[7] = flag_q && (idx_q == '0);
        end
    end

endmodule

// File: tb/tb_alu_7seg_scan.sv
module tb_alu_7seg_scan;

    localparam int WIDTH    = 8;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 2;
    localparam int LZB      = 1;

    logic clk;
    logic rst;

    alu_7seg_scan_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    alu_7seg_scan #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .LZB(LZB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // Reference model: architectural state only; scan position is derived
    // from the number of clock edges since the last reset.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int m_r     = 0;
    bit m_flag  = 0;
    bit m_valid = 0;
    bit m_en    = 0;
    int m_cnt   = 0;
    bit known   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_r <= 0; m_flag <= 0; m_valid <= 0; m_en <= 0; m_cnt <= 0; known <= 1;
        end else begin
            int a, b;
            a = int'(bus.a);
            b = int'(bus.b);
            m_cnt <= m_cnt + 1;
            m_en  <= bus.e;
            if (bus.e && bus.load) begin
                m_valid <= 1;
                case (bus.opcode)
                    2'b00: begin m_r <= (a + b) % 256;       m_flag <= (a + b) > 255; end
                    2'b01: begin m_r <= (a - b + 256) % 256; m_flag <= a < b;         end
                    2'b10: begin m_r <= a & b;               m_flag <= 0;             end
                    default: begin m_r <= a ^ b;             m_flag <= 0;             end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (known) begin
            int idx, upper;
            logic [7:0] exp_seg;
            logic [3:0] exp_an;
            exp_seg = 8'h00;
            exp_an  = 4'h0;
            if (m_en && m_valid) begin
                idx    = (m_cnt / SCAN_DIV) % DIGITS;
                upper  = m_r >> (4 * idx);
                exp_an = 4'(1 << idx);
                if (!(LZB != 0 && idx != 0 && upper == 0))
                    exp_seg[6:0] = hex_tab[upper % 16];
                exp_seg[7] = (idx == 0) && m_flag;
            end
            check("seg", 32'(bus.seg), 32'(exp_seg));
            check("an", 32'(bus.an), 32'(exp_an));
            check("valid", 32'(bus.valid), 32'(m_valid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus.a = a; bus.b = b; bus.opcode = op; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        int cnt_d0;
        bit found;
        rst = 1'b1; bus.e = 1'b1; bus.load = 1'b0;
        bus.a = '0; bus.b = '0; bus.opcode = 2'b00;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_seg", 32'(bus.seg), 32'h00);
            check("reset_an", 32'(bus.an), 32'h0);
            check("reset_valid", 32'(bus.valid), 32'h0);
        end

        // 3C + 05 = 41: digits 1,4 then blanks
        do_load(8'h3C, 8'h05, 2'b00);
        @(negedge clk);
        check("add41_valid", 32'(bus.valid), 32'h1);
        check("model_r41", 32'(m_r), 32'h41);
        cnt_d0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.an == 4'b0001) begin cnt_d0++; check("add41_d0", 32'(bus.seg), 32'h06); end
            else if (bus.an == 4'b0010) check("add41_d1", 32'(bus.seg), 32'h66);
            else if (bus.an == 4'b0100) check("add41_d2", 32'(bus.seg), 32'h00);
            else check("add41_d3", 32'({bus.an, bus.seg}), 32'h800);
        end
        check("hold_cycles_d0", 32'(cnt_d0), 32'd2);

        // FF + 01 = 00 with carry
        do_load(8'hFF, 8'h01, 2'b00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.an == 4'b0001) check("carry_d0", 32'(bus.seg), 32'hBF);
            else check("carry_dn", 32'(bus.seg), 32'h00);
        end

        // 05 - 07 = FE with borrow
        do_load(8'h05, 8'h07, 2'b01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.an == 4'b0001) check("sub_d0", 32'(bus.seg), 32'hF9);
            else if (bus.an == 4'b0010) check("sub_d1", 32'(bus.seg), 32'h71);
            else check("sub_dn", 32'(bus.seg), 32'h00);
        end

        // Load ignored while disabled; display dark
        @(negedge clk);
        bus.e = 1'b0;
        do_load(8'h12, 8'h34, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dis_an", 32'(bus.an), 32'h0);
            check("dis_seg", 32'(bus.seg), 32'h00);
        end
        bus.e = 1'b1;
        tick();
        @(negedge clk);
        check("reen_an_nonzero", 32'(bus.an != 4'h0), 32'h1);
        if (bus.an == 4'b0001) check("reen_d0", 32'(bus.seg), 32'hF9);
        else if (bus.an == 4'b0010) check("reen_d1", 32'(bus.seg), 32'h71);
        else check("reen_dn", 32'(bus.seg), 32'h00);

        // Reset at idx=2 with a concurrent load that must be discarded
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.an == 4'b0100) found = 1;
        end
        check("wait_idx2", 32'(found), 32'h1);
        rst = 1'b1; bus.load = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.opcode = 2'b00;
        tick();
        rst = 1'b0; bus.load = 1'b0;
        @(negedge clk);
        check("rst_an", 32'(bus.an), 32'h0);
        check("rst_seg", 32'(bus.seg), 32'h00);
        check("rst_valid", 32'(bus.valid), 32'h0);
        do_load(8'h3C, 8'h05, 2'b00);
        @(negedge clk);
        check("restart_an", 32'(bus.an), 32'h1);
        check("restart_seg", 32'(bus.seg), 32'h06);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            bus.e      = ($urandom_range(0, 7) != 0);
            bus.load   = ($urandom_range(0, 2) == 0);
            bus.a      = 8'($urandom);
            bus.b      = 8'($urandom);
            bus.opcode = 2'($urandom);
            if ($urandom_range(0, 7) == 0) bus.a = 8'h00;
            if ($urandom_range(0, 7) == 0) bus.b = bus.a;
            tick();
        end
        rst = 1'b0; bus.load = 1'b0;
        tick();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_7seg_scan.md
Name: alu_7seg_scan

Overview:
Parametrised registered ALU with a time-multiplexed multi-digit hexadecimal 7-segment display driver. It is the successor to the single-digit combinational ALU-to-7-seg block. Operands are captured on a load strobe and the result is held in a register. A scan counter cycles through DIGITS display positions, and the block drives one shared segment bus plus one-hot digit enables. It sits between the operand source (switches or upstream logic) and the board's multiplexed display.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
DIGITS, 4, number of display digits; must be >= ceil(WIDTH/4)
SCAN_DIV, 2, clock cycles each digit is held active before advancing (>=1)
LZB, 1, 1 = leading-zero digits blanked; 0 = all digits shown

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  2  00 ADD, 01 SUB (a-b), 10 AND, 11 XOR
e  input  1  enable: gates load and display
load  input  1  capture strobe, sampled when e=1
seg  output  8  {dp,g,f,e,d,c,b,a}, active-high
an  output  DIGITS  one-hot digit enable, active-high, bit k = digit k (digit 0 = LS nibble)
valid  output  1  result register holds a computed value

Behaviour:
- Reset (rst=1 at a rising edge): R=0, flag=0, valid=0, digit index idx=0, prescaler=0. seg=0 and an=0 from the following cycle until the first load.
- Load: at a rising edge with e=1 and load=1, R<=op(a,b)[WIDTH-1:0], flag<=carry/borrow and valid<=1. Result is visible the cycle after the strobe (latency 1).
  - ADD: {flag,R} = a+b, WIDTH+1 bits.
  - SUB: R = a-b mod 2^WIDTH; flag=1 iff a<b.
  - AND/XOR: flag=0.
  - Consecutive load cycles each overwrite R.
- load with e=0 is ignored; R, flag and valid are unchanged.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 every cycle, independent of e and load. It wraps to 0 at terminal count.
  - On terminal count, idx advances; it wraps from DIGITS-1 to 0.
  - SCAN_DIV=1 advances idx every cycle.
  - A load never disturbs the prescaler or idx.
- Outputs are decoded only from registers (no combinational path from inputs to seg/an).
  - If e=0 or valid=0: an=0 and seg=0.
  - Otherwise an=1<<idx and seg[6:0]=hex pattern of nibble idx of R. Nibbles above WIDTH are zero-padded.
- Hex patterns ({g..a}): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- dp (seg[7]) = flag when idx=0; 0 on all other digits.
- LZB=1: digit k>=1 is blanked (seg=0, an still asserted) when nibbles k..DIGITS-1 of R are all zero. Digit 0 is never blanked, so R=0 shows "0".
- Re-asserting e after e=0 restores the display of the retained R immediately (same idx).
- rst mid-scan or mid-load has priority: the state clears at that edge and a concurrent load is discarded.

Test Plan:
- Reset with e=1 -> seg=00, an=0000, valid=0 for all cycles until a load.
- WIDTH=8, DIGITS=4, SCAN_DIV=2; load a=3C, b=05, op=00 -> R=41, flag=0, valid=1. Each digit is held 2 cycles:
  - an=0001 seg=06
  - an=0010 seg=66
  - an=0100 seg=00
  - an=1000 seg=00
  - then wraps to an=0001.
- a=FF, b=01, op=00 -> R=00, flag=1. Digit 0 seg=BF; digits 1-3 seg=00.
- a=05, b=07, op=01 -> R=FE, flag=1. Digit 0 seg=F9 ('E'+dp); digit 1 seg=71 ('F').
- With e=0, pulse load with a=12, b=34, op=11 -> R unchanged, an=0000, seg=00. Raise e -> the previous value is redisplayed at the current idx.
- Assert rst for 1 cycle mid-scan at idx=2 -> next cycle an=0000, seg=00, valid=0. After a load, scanning restarts from an=0001.
